// File: rtl/car_pkg.sv
// car_pkg: shared definitions for the car position update scheduler.
//   NUM_CARS_DEF  - default number of cars
//   POS_W/SPD_W   - position and speed widths
//   MAX_CARS      - storage depth, set by the 4-bit car index
//   car_state_t   - sweep FSM state encoding
//   reset_x/reset_y/reset_speed - per-car reset tables
package car_pkg;

  localparam int NUM_CARS_DEF = 10;
  localparam int POS_W        = 6;
  localparam int SPD_W        = 6;
  localparam int IDX_W        = 4;
  localparam int MAX_CARS     = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } car_state_t;

  function automatic logic [POS_W-1:0] reset_x(input logic [IDX_W-1:0] idx);
    return POS_W'(idx) + POS_W'(1);
  endfunction

  // Lane table; slots 10..15 continue upward so larger builds stay distinct.
  function automatic logic [POS_W-1:0] reset_y(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0:    return 6'd1;
      4'd1:    return 6'd2;
      4'd2:    return 6'd3;
      4'd3:    return 6'd4;
      4'd4:    return 6'd5;
      4'd5:    return 6'd8;
      4'd6:    return 6'd9;
      4'd7:    return 6'd10;
      4'd8:    return 6'd11;
      4'd9:    return 6'd12;
      4'd10:   return 6'd13;
      4'd11:   return 6'd14;
      4'd12:   return 6'd15;
      4'd13:   return 6'd16;
      4'd14:   return 6'd17;
      default: return 6'd18;
    endcase
  endfunction

  function automatic logic [SPD_W-1:0] reset_speed(input logic [IDX_W-1:0] idx);
    return (idx == idx) ? SPD_W'(1) : SPD_W'(1);
  endfunction

endpackage

// File: rtl/car_tick_gen.sv
// car_tick_gen: slowdown counter producing one tick every c_SLOW_COUNT
// enabled clocks.
//   i_Clk     - clock, rising edge
//   i_Rst_L   - asynchronous active-low reset
//   i_Enable  - counter advances while high, holds while low
//   o_Tick    - one-cycle pulse in the enabled cycle where the count wraps
module car_tick_gen #(
  parameter int c_SLOW_COUNT  = 2000000,
  parameter int COUNTER_WIDTH = 26
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Enable,
  output logic o_Tick
);

  localparam logic [COUNTER_WIDTH-1:0] TERM = COUNTER_WIDTH'(c_SLOW_COUNT - 1);

  logic [COUNTER_WIDTH-1:0] r_count;
  logic                     w_term;

  assign w_term = i_Enable && (r_count == TERM);
  assign o_Tick = w_term;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_count <= '0;
    end else if (w_term) begin
      r_count <= '0;
    end else if (i_Enable) begin
      r_count <= r_count + COUNTER_WIDTH'(1);
    end
  end

endmodule

// File: rtl/car_update_sched.sv
// car_update_sched: periodically sweeps all cars, advancing each X by its
// speed, while sharing the single-port position store with a read port.
//
// State table:
//   ST_IDLE   | waiting for a tick
//   ST_UPDATE | one car per granted cycle, index 0..NUM_CARS-1
//   ST_DONE   | end-of-sweep pulse, back to idle
//
// Ports:
//   i_Clk, i_Rst_L                  - clock, async active-low reset
//   i_Enable                        - tick counter run enable
//   i_Cfg_Wr/i_Cfg_Idx/i_Cfg_Speed  - per-car speed write
//   i_Rd_Req/i_Rd_Idx               - position read request (held until granted)
//   o_Rd_Valid/o_Rd_X/o_Rd_Y        - read response, one cycle after grant
//   o_Busy/o_Frame_Done/o_Overrun   - sweep active, sweep end, sticky dropped tick
//
// Build option: CAR_REVERSE_EN makes odd-indexed cars move toward lower X.
module car_update_sched
  import car_pkg::*;
#(
  parameter int NUM_CARS      = NUM_CARS_DEF,
  parameter int c_MAX_X       = 20,
  parameter int c_SLOW_COUNT  = 2000000,
  parameter int COUNTER_WIDTH = 26
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Enable,
  input  logic             i_Cfg_Wr,
  input  logic [IDX_W-1:0] i_Cfg_Idx,
  input  logic [SPD_W-1:0] i_Cfg_Speed,
  input  logic             i_Rd_Req,
  input  logic [IDX_W-1:0] i_Rd_Idx,
  output logic             o_Rd_Valid,
  output logic [POS_W-1:0] o_Rd_X,
  output logic [POS_W-1:0] o_Rd_Y,
  output logic             o_Busy,
  output logic             o_Frame_Done,
  output logic             o_Overrun
);

  localparam logic [IDX_W:0]   NCARS    = (IDX_W+1)'(NUM_CARS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CARS - 1);
  localparam logic [POS_W:0]   MAX_X    = (POS_W+1)'(c_MAX_X);

  car_state_t       r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_upd_turn;
  logic             r_busy;
  logic             r_frame_done;
  logic             r_overrun;
  logic [POS_W-1:0] r_x     [MAX_CARS];
  logic [SPD_W-1:0] r_speed [MAX_CARS];
  logic             r_rd_valid;
  logic [POS_W-1:0] r_rd_x;
  logic [POS_W-1:0] r_rd_y;

  logic             w_tick;
  logic             w_conflict;
  logic             w_grant_rd;
  logic             w_grant_upd;
  logic [POS_W-1:0] w_cur_x;
  logic [SPD_W-1:0] w_cur_spd;
  logic [POS_W:0]   w_sum;
  logic [POS_W-1:0] w_new_x;

  car_tick_gen #(
    .c_SLOW_COUNT (c_SLOW_COUNT),
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_tick (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Enable(i_Enable),
    .o_Tick  (w_tick)
  );

  // Store has one access per cycle; on conflict r_upd_turn alternates,
  // and any conflict-free cycle puts the read first again.
  assign w_conflict  = (r_state == ST_UPDATE) && i_Rd_Req;
  assign w_grant_rd  = i_Rd_Req && !(w_conflict && r_upd_turn);
  assign w_grant_upd = (r_state == ST_UPDATE) && !(i_Rd_Req && !r_upd_turn);

  assign w_cur_x   = r_x[r_idx];
  assign w_cur_spd = r_speed[r_idx];
  assign w_sum     = {1'b0, w_cur_x} + {1'b0, w_cur_spd};

`ifdef CAR_REVERSE_EN
  localparam logic [POS_W-1:0] MAX_X_M1 = POS_W'(c_MAX_X - 1);
  logic [POS_W-1:0] w_fwd_x;
  logic [POS_W-1:0] w_rev_x;
  assign w_fwd_x = (w_sum < MAX_X) ? w_sum[POS_W-1:0] : '0;
  assign w_rev_x = (w_cur_x >= w_cur_spd) ? (w_cur_x - w_cur_spd) : MAX_X_M1;
  assign w_new_x = r_idx[0] ? w_rev_x : w_fwd_x;
`else
  assign w_new_x = (w_sum < MAX_X) ? w_sum[POS_W-1:0] : '0;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_upd_turn   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      for (int i = 0; i < MAX_CARS; i++) begin
        r_x[i] <= (i < NUM_CARS) ? reset_x(IDX_W'(i)) : '0;
      end
    end else begin
      r_frame_done <= 1'b0;
      r_upd_turn   <= w_conflict ? !r_upd_turn : 1'b0;
      if (w_tick && r_busy) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            r_state <= ST_UPDATE;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_UPDATE: begin
          if (w_grant_upd) begin
            r_x[r_idx] <= w_new_x;
            if (r_idx == LAST_IDX) begin
              r_state      <= ST_DONE;
              r_frame_done <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // A write landing on the car being updated this cycle is not seen by the
  // update (it already used the old value), so it applies next sweep.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int i = 0; i < MAX_CARS; i++) begin
        r_speed[i] <= (i < NUM_CARS) ? reset_speed(IDX_W'(i)) : '0;
      end
    end else if (i_Cfg_Wr && ({1'b0, i_Cfg_Idx} < NCARS)) begin
      r_speed[i_Cfg_Idx] <= i_Cfg_Speed;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_rd_valid <= 1'b0;
      r_rd_x     <= '0;
      r_rd_y     <= '0;
    end else begin
      r_rd_valid <= w_grant_rd;
      if (w_grant_rd) begin
        if ({1'b0, i_Rd_Idx} < NCARS) begin
          r_rd_x <= r_x[i_Rd_Idx];
          r_rd_y <= reset_y(i_Rd_Idx);
        end else begin
          r_rd_x <= '0;
          r_rd_y <= '0;
        end
      end
    end
  end

  assign o_Rd_Valid   = r_rd_valid;
  assign o_Rd_X       = r_rd_x;
  assign o_Rd_Y       = r_rd_y;
  assign o_Busy       = r_busy;
  assign o_Frame_Done = r_frame_done;
  assign o_Overrun    = r_overrun;

endmodule
